// File: rtl/cmd_script_player_if.sv
// remoteComm command/response handshake between the script player and the link.
interface cmd_script_player_if #(
    parameter int CMD_W  = 16,
    parameter int RESP_W = 8
);
    logic [CMD_W-1:0]  cmd;
    logic              send_cmd;
    logic              cmd_sent;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp;

    modport master (output cmd, send_cmd, input cmd_sent, resp_rdy, resp);
    modport slave  (input cmd, send_cmd, output cmd_sent, resp_rdy, resp);
endinterface

// File: rtl/cmd_script_player.sv
// Replays a loaded script of commands through remoteComm and checks each
// response against the expected byte stored alongside its command.
module cmd_script_player #(
    parameter int DEPTH  = 16,
    parameter int CMD_W  = 16,
    parameter int RESP_W = 8,
    parameter int TO_W   = 26,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [RESP_W-1:0] wr_exp,
    input  logic [AW:0]       num_cmds,
    input  logic              start,
    input  logic              abort,
    input  logic              stop_on_err,
    cmd_script_player_if.master rc,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              timed_out,
    output logic [AW:0]       pass_cnt,
    output logic [AW:0]       fail_cnt,
    output logic [AW-1:0]     fail_idx
);

    typedef enum logic [2:0] {
        IDLE, FETCH, SEND, WAIT_SENT, WAIT_RESP, NEXT, FIN
    } state_t;

    // Timeout fires on the (2^TO_W - 1)th consecutive wait cycle.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
    localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]     CNT_MAX = (AW+1)'(DEPTH);

    state_t state, next_state;

    logic [CMD_W-1:0]  mem_cmd [DEPTH];
    logic [RESP_W-1:0] mem_exp [DEPTH];

    logic [CMD_W-1:0]  rd_cmd;
    logic [RESP_W-1:0] rd_exp;
    logic [AW-1:0]     idx;
    logic [AW:0]       num_q;
    logic [AW:0]       num_clip;
    logic              soe_q;
    logic              ent_fail;
    logic [TO_W-1:0]   to_cnt;

    logic abort_now, to_hit, last, timeout, resp_ok, resp_bad, entry_bad;

    // Condition decode shared by the next-state and datapath logic
    always_comb begin
        num_clip  = (num_cmds > CNT_MAX) ? CNT_MAX : num_cmds;
        abort_now = abort && (state != IDLE);
        to_hit    = (to_cnt == TO_LAST);
        last      = ({1'b0, idx} == (num_q - CNT_ONE));
        timeout   = ((state == WAIT_SENT) && !rc.cmd_sent && to_hit) ||
                    ((state == WAIT_RESP) && !rc.resp_rdy && to_hit);
        resp_ok   = (state == WAIT_RESP) && rc.resp_rdy && (rc.resp == rd_exp);
        resp_bad  = (state == WAIT_RESP) && rc.resp_rdy && (rc.resp != rd_exp);
        entry_bad = timeout || resp_bad;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; abort outranks everything outside IDLE
    always_comb begin
        next_state = state;
        if (abort_now) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      if (start) next_state = (num_clip == '0) ? FIN : FETCH;
                FETCH:     next_state = SEND;
                SEND:      next_state = WAIT_SENT;
                WAIT_SENT: if (rc.cmd_sent) next_state = WAIT_RESP;
                           else if (to_hit) next_state = NEXT;
                WAIT_RESP: if (rc.resp_rdy || to_hit) next_state = NEXT;
                NEXT:      next_state = ((ent_fail && soe_q) || last) ? FIN : FETCH;
                FIN:       next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        busy        = (state != IDLE);
        rc.send_cmd = (state == SEND) && !abort;
        done        = (state == FIN) && !abort;
    end

    // The read register doubles as the cmd output, so cmd only changes on a fetch
    assign rc.cmd = rd_cmd;

    // Script RAM write port; writes are dropped during playback
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) begin
            mem_cmd[wr_addr] <= wr_cmd;
            mem_exp[wr_addr] <= wr_exp;
        end
    end

    // Playback datapath: read register, timeout counter, results; frozen by abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cmd    <= '0;
            rd_exp    <= '0;
            idx       <= '0;
            num_q     <= '0;
            soe_q     <= 1'b0;
            ent_fail  <= 1'b0;
            to_cnt    <= '0;
            fail      <= 1'b0;
            timed_out <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_idx  <= '0;
        end else if (!abort_now) begin
            if ((state == IDLE) && start) begin
                fail      <= 1'b0;
                timed_out <= 1'b0;
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                fail_idx  <= '0;
                soe_q     <= stop_on_err;
                num_q     <= num_clip;
                idx       <= '0;
            end
            if (state == FETCH) begin
                rd_cmd <= mem_cmd[idx];
                rd_exp <= mem_exp[idx];
            end
            if (state == SEND) ent_fail <= 1'b0;
            if ((state == SEND) || ((state == WAIT_SENT) && rc.cmd_sent))
                to_cnt <= '0;
            else if ((state == WAIT_SENT) || (state == WAIT_RESP))
                to_cnt <= to_cnt + TO_W'(1);
            if (resp_ok) pass_cnt <= pass_cnt + CNT_ONE;
            if (entry_bad) begin
                ent_fail <= 1'b1;
                fail_cnt <= fail_cnt + CNT_ONE;
                fail     <= 1'b1;
                if (!fail) fail_idx <= idx;
            end
            if (timeout) timed_out <= 1'b1;
            if ((state == NEXT) && (next_state == FETCH)) idx <= idx + AW'(1);
        end
    end

endmodule

// File: tb/tb_cmd_script_player.sv
// Directed bench for cmd_script_player with a hand-driven remoteComm.
module tb_cmd_script_player;
    localparam int DEPTH = 16;
    localparam int CMD_W = 16;
    localparam int RESP_W = 8;
    localparam int TO_W = 6;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [CMD_W-1:0] wr_cmd = '0;
    logic [RESP_W-1:0] wr_exp = '0;
    logic [AW:0] num_cmds = '0;
    logic start = 1'b0, abort = 1'b0, stop_on_err = 1'b0;
    logic busy, done, fail, timed_out;
    logic [AW:0] pass_cnt, fail_cnt;
    logic [AW-1:0] fail_idx;

    int checks = 0;
    int errors = 0;
    int sends = 0;
    int dones = 0;
    int s0, d0;
    logic [15:0] scmd [DEPTH];

    cmd_script_player_if #(.CMD_W(CMD_W), .RESP_W(RESP_W)) rc_if ();

    cmd_script_player #(.DEPTH(DEPTH), .CMD_W(CMD_W), .RESP_W(RESP_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cmd(wr_cmd),
        .wr_exp(wr_exp), .num_cmds(num_cmds), .start(start), .abort(abort),
        .stop_on_err(stop_on_err), .rc(rc_if), .busy(busy), .done(done), .fail(fail),
        .timed_out(timed_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    // Pulse monitors
    always @(posedge clk) begin
        if (rc_if.send_cmd) sends++;
        if (done) dones++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [15:0] c, input logic [7:0] e);
        wr_en = 1'b1; wr_addr = AW'(a); wr_cmd = c; wr_exp = e;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input int n, input logic soe);
        num_cmds = (AW+1)'(n); stop_on_err = soe; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for the send strobe, checks cmd, acknowledges, optionally responds
    task automatic serve(input logic [15:0] ecmd, input logic [7:0] rsp, input bit give_resp,
                         input int egap, input string tag);
        int waited = 0;
        do begin
            tick();
            waited++;
        end while (!rc_if.send_cmd && waited < 20);
        chk($sformatf("%s_gap", tag), waited, egap);
        chk($sformatf("%s_cmd", tag), rc_if.cmd, ecmd);
        tick();
        rc_if.cmd_sent = 1'b1;
        tick();
        rc_if.cmd_sent = 1'b0;
        if (give_resp) begin
            rc_if.resp_rdy = 1'b1; rc_if.resp = rsp;
            tick();
            rc_if.resp_rdy = 1'b0;
        end
    endtask

    task automatic finish_run(input string tag);
        tick();
        chk($sformatf("%s_done_hi", tag), done, 1);
        chk($sformatf("%s_busy_fin", tag), busy, 1);
        tick();
        chk($sformatf("%s_done_lo", tag), done, 0);
        chk($sformatf("%s_busy_lo", tag), busy, 0);
    endtask

    initial begin
        rc_if.cmd_sent = 1'b0; rc_if.resp_rdy = 1'b0; rc_if.resp = '0;
        scmd[0] = 16'h4001; scmd[1] = 16'h4BF1; scmd[2] = 16'h47F1; scmd[3] = 16'h43F1;
        for (int i = 4; i < DEPTH; i++) scmd[i] = 16'h1000 + 16'(i);

        // Reset values
        tick(); tick();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_send", rc_if.send_cmd, 0);
        chk("rst_cmd", rc_if.cmd, 0); chk("rst_fail", fail, 0); chk("rst_to", timed_out, 0);
        chk("rst_pass", pass_cnt, 0); chk("rst_fcnt", fail_cnt, 0); chk("rst_fidx", fail_idx, 0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) load(i, scmd[i], 8'hA5);

        // All pass
        s0 = sends; d0 = dones;
        start_run(4, 1'b0);
        chk("t1_fetch_busy", busy, 1); chk("t1_fetch_send", rc_if.send_cmd, 0);
        for (int i = 0; i < 4; i++) serve(scmd[i], 8'hA5, 1'b1, (i == 0) ? 1 : 2, "t1");
        finish_run("t1");
        chk("t1_sends", sends - s0, 4); chk("t1_dones", dones - d0, 1);
        chk("t1_pass", pass_cnt, 4); chk("t1_fcnt", fail_cnt, 0); chk("t1_fail", fail, 0);
        chk("t1_cmd_hold", rc_if.cmd, 16'h43F1);

        // Mismatch on entry 2, continue
        s0 = sends;
        start_run(4, 1'b0);
        for (int i = 0; i < 4; i++) serve(scmd[i], (i == 2) ? 8'h5A : 8'hA5, 1'b1, (i == 0) ? 1 : 2, "t2a");
        finish_run("t2a");
        chk("t2a_sends", sends - s0, 4); chk("t2a_pass", pass_cnt, 3); chk("t2a_fcnt", fail_cnt, 1);
        chk("t2a_fidx", fail_idx, 2); chk("t2a_fail", fail, 1); chk("t2a_to", timed_out, 0);

        // Mismatch on entry 2, stop on error
        s0 = sends;
        start_run(4, 1'b1);
        for (int i = 0; i < 3; i++) serve(scmd[i], (i == 2) ? 8'h5A : 8'hA5, 1'b1, (i == 0) ? 1 : 2, "t2b");
        finish_run("t2b");
        chk("t2b_sends", sends - s0, 3); chk("t2b_pass", pass_cnt, 2); chk("t2b_fcnt", fail_cnt, 1);
        chk("t2b_fidx", fail_idx, 2);

        // Response timeout on entry 1 (63 wait cycles with TO_W=6)
        start_run(4, 1'b0);
        serve(scmd[0], 8'hA5, 1'b1, 1, "t3");
        serve(scmd[1], 8'h00, 1'b0, 2, "t3");
        repeat (62) tick();
        chk("t3_fail_early", fail, 0);
        tick();
        chk("t3_fail", fail, 1); chk("t3_to", timed_out, 1); chk("t3_fidx", fail_idx, 1);
        serve(scmd[2], 8'hA5, 1'b1, 2, "t3");
        serve(scmd[3], 8'hA5, 1'b1, 2, "t3");
        finish_run("t3");
        chk("t3_pass", pass_cnt, 3); chk("t3_fcnt", fail_cnt, 1); chk("t3_to_end", timed_out, 1);

        // Empty script
        s0 = sends;
        start_run(0, 1'b0);
        chk("t4a_done", done, 1);
        tick();
        chk("t4a_done_lo", done, 0); chk("t4a_busy", busy, 0); chk("t4a_pass", pass_cnt, 0);
        chk("t4a_fcnt", fail_cnt, 0); chk("t4a_to", timed_out, 0); chk("t4a_sends", sends - s0, 0);

        // Oversized count clips to DEPTH
        s0 = sends;
        start_run(DEPTH + 5, 1'b0);
        for (int i = 0; i < DEPTH; i++) serve(scmd[i], 8'hA5, 1'b1, (i == 0) ? 1 : 2, "t4b");
        finish_run("t4b");
        chk("t4b_sends", sends - s0, DEPTH); chk("t4b_pass", pass_cnt, DEPTH);

        // Abort in WAIT_RESP of entry 1
        s0 = sends; d0 = dones;
        start_run(4, 1'b0);
        serve(scmd[0], 8'hA5, 1'b1, 1, "t5");
        serve(scmd[1], 8'h00, 1'b0, 2, "t5");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", busy, 0); chk("t5_pass", pass_cnt, 1);
        rc_if.resp_rdy = 1'b1; rc_if.resp = 8'h5A;
        tick();
        rc_if.resp_rdy = 1'b0;
        tick();
        chk("t5_pass_after", pass_cnt, 1); chk("t5_fcnt", fail_cnt, 0); chk("t5_fail", fail, 0);
        chk("t5_dones", dones - d0, 0); chk("t5_sends", sends - s0, 2); chk("t5_busy_after", busy, 0);

        // Reset asserted in WAIT_SENT of entry 1
        start_run(4, 1'b0);
        serve(scmd[0], 8'h5A, 1'b1, 1, "t6");
        begin
            int w = 0;
            do begin
                tick();
                w++;
            end while (!rc_if.send_cmd && w < 20);
            chk("t6_gap", w, 2);
        end
        tick();
        chk("t6_fail_pre", fail, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_cmd", rc_if.cmd, 0); chk("t6_busy", busy, 0); chk("t6_fail", fail, 0);
        chk("t6_fcnt", fail_cnt, 0); chk("t6_send", rc_if.send_cmd, 0); chk("t6_done", done, 0);
        chk("t6_to", timed_out, 0); chk("t6_fidx", fail_idx, 0); chk("t6_pass", pass_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Writes while busy are dropped
        start_run(1, 1'b0);
        wr_en = 1'b1; wr_addr = '0; wr_cmd = 16'hBEEF; wr_exp = 8'h00;
        serve(16'h4001, 8'hA5, 1'b1, 1, "t7a");
        wr_en = 1'b0;
        finish_run("t7a");
        start_run(1, 1'b0);
        serve(16'h4001, 8'hA5, 1'b1, 1, "t7b");
        finish_run("t7b");
        chk("t7_pass", pass_cnt, 1); chk("t7_fcnt", fail_cnt, 0); chk("t7_cmd_hold", rc_if.cmd, 16'h4001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmd_script_player.md
# cmd_script_player

Synthesizable command sequencer that replays a loaded script of 16-bit Knight commands through remoteComm and checks each 8-bit response against a per-entry expected value. It sits between a host/BIST controller and remoteComm (cmd/send_cmd/cmd_sent/resp_rdy/resp). It generalises the directed bench flow (send, wait, check 0xA5) into parametrised depth, per-entry expected responses, timeouts, and a stop-on-error mode.

## Interface
- DEPTH, 16, number of script slots (power of 2, ≥2)
- CMD_W, 16, command width
- RESP_W, 8, response width
- TO_W, 26, timeout counter width; timeout fires after 2^TO_W−1 cycles in a wait state
- AW, $clog2(DEPTH), slot address width (derived, not overridable)

- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write script slot (ignored while busy)
- wr_addr  in  AW  slot index
- wr_cmd  in  CMD_W  command for slot
- wr_exp  in  RESP_W  expected response for slot
- num_cmds  in  AW+1  entries to play; values >DEPTH clip to DEPTH
- start  in  1  begin playback (sampled only in IDLE)
- abort  in  1  terminate playback
- stop_on_err  in  1  1 = halt at first failure; 0 = continue (sampled at start)
- cmd  out  CMD_W  command to remoteComm
- send_cmd  out  1  one-cycle send strobe
- cmd_sent  in  1  remoteComm transmit complete
- resp_rdy  in  1  response valid strobe
- resp  in  RESP_W  response byte
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse at normal/stop-on-error completion
- fail  out  1  sticky: any mismatch or timeout this run
- timed_out  out  1  sticky: any timeout this run
- pass_cnt  out  AW+1  entries passed
- fail_cnt  out  AW+1  entries failed
- fail_idx  out  AW  index of first failure

## Operation
- Script RAM: DEPTH×(CMD_W+RESP_W), synchronous write, synchronous (registered) read.
- States: IDLE, FETCH, SEND, WAIT_SENT, WAIT_RESP, NEXT, FIN.
- IDLE: on start, clear fail, timed_out, pass_cnt, fail_cnt, fail_idx; latch stop_on_err and clipped num_cmds; idx←0. num_cmds==0 → FIN; else → FETCH.
- FETCH: issue RAM read of idx → SEND.
- SEND: cmd←RAM cmd, exp←RAM exp, send_cmd=1 for this cycle only → WAIT_SENT; clear timeout counter.
- WAIT_SENT: on cmd_sent → WAIT_RESP (counter cleared). resp_rdy here ignored.
- WAIT_RESP: on resp_rdy, compare resp to exp: equal → pass_cnt++; else fail_cnt++, fail←1, record fail_idx if first failure → NEXT.
- Timeout in either wait state: fail_cnt++, fail←1, timed_out←1, record fail_idx if first → NEXT.
- NEXT: if failed this entry and stop_on_err → FIN; if idx==num−1 → FIN; else idx++ → FETCH.
- FIN: done=1 one cycle → IDLE.
- abort (any non-IDLE state, highest priority): → IDLE next cycle, no done pulse, counters/flags retain values, send_cmd 0.
- cmd holds last sent value between entries and after completion.
- Counters saturate at DEPTH (cannot exceed by construction).

## Timing
- Reset: state IDLE, cmd 0, send_cmd 0, busy 0, done 0, fail 0, timed_out 0, pass_cnt 0, fail_cnt 0, fail_idx 0; RAM contents undefined.
- busy = (state != IDLE), registered from state.
- start sampled at edge k → FETCH at k+1, SEND (send_cmd high) at k+2, WAIT_SENT at k+3.
- resp_rdy at edge m in WAIT_RESP → counters updated at m+1 (NEXT); next send_cmd at m+3.
- Last entry: done high exactly one cycle, two cycles after accepting its response; busy falls same edge done falls.
- Timeout: counter increments each wait cycle; at 2^TO_W−1 with no event → NEXT.
- wr_en while busy: dropped. start while busy: ignored. start and abort together in IDLE: start wins.
- cmd_sent and timeout same cycle: cmd_sent wins; likewise resp_rdy beats timeout.

## Test plan
- Load 4 entries {4001/A5, 4BF1/A5, 47F1/A5, 43F1/A5}, num_cmds=4, remote model always answers A5 → 4 send_cmd pulses, pass_cnt=4, fail_cnt=0, fail=0, single done pulse.
- Same script, entry 2 answered 5A, stop_on_err=0 → pass_cnt=3, fail_cnt=1, fail_idx=2, 4 sends; with stop_on_err=1 → 3 sends, done after entry 2.
- TO_W=6, model never asserts resp_rdy for entry 1 → timed_out=1, fail_idx=1 after 63 wait cycles, playback continues to entry 2.
- num_cmds=0 → no send_cmd, done pulses at k+1 after start, counters 0; num_cmds=DEPTH+5 → exactly DEPTH sends.
- abort in WAIT_RESP of entry 1 → IDLE next cycle, no done, pass_cnt=1; stray resp_rdy afterward changes nothing.
- Assert rst_n low mid-WAIT_SENT → all outputs to reset values immediately; wr_en during busy leaves RAM unchanged on re-run.
